// File: rtl/sysid_info_regs.sv
// System-ID register slave: ID/timestamp/caps/scratch, plus an optional 64-bit uptime counter (SYSID_UPTIME_EN).
// Reads return after READ_LATENCY cycles on readdatavalid; there is no waitrequest, so every request is accepted at once.
module sysid_info_regs #(
   parameter logic [31:0] SYS_ID        = 32'h0000_00A5,
   parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
   parameter logic [15:0] VERSION       = 16'h0002,
   parameter int          READ_LATENCY  = 1,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   output logic        readdatavalid
);

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
         $error("sysid_info_regs: READ_LATENCY must be in 1..3");
      end
   endgenerate

`ifdef SYSID_UPTIME_EN
   localparam logic UPTIME_PRESENT = 1'b1;
`else
   localparam logic UPTIME_PRESENT = 1'b0;
`endif
   localparam logic [7:0]  LAT8 = 8'(READ_LATENCY);
   localparam logic [31:0] CAPS = {VERSION, LAT8, 7'b0, UPTIME_PRESENT};

   // A simultaneous write wins; the read is dropped entirely.
   logic rd_acc;
   assign rd_acc = read & ~write;

   logic [31:0] scratch;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch <= SCRATCH_RESET;
      end else if (write && address == 3'd4) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) scratch[8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

`ifdef SYSID_UPTIME_EN
   logic [63:0] uptime;
   logic [31:0] uptime_hi_shadow;
   logic        freeze;
   logic        ctrl_wr;
   logic        clr;

   assign ctrl_wr = write && address == 3'd6;
   assign clr     = ctrl_wr && writedata[0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         uptime           <= '0;
         uptime_hi_shadow <= '0;
         freeze           <= 1'b0;
      end else begin
         if (clr)          uptime <= '0;
         else if (!freeze) uptime <= uptime + 64'd1;
         if (ctrl_wr)      freeze <= writedata[1];
         // Upper half is taken from the same edge that samples LO, keeping the pair coherent.
         if (rd_acc && address == 3'd2) uptime_hi_shadow <= uptime[63:32];
      end
   end
`endif

   logic [31:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (address)
         3'd0: rd_mux = SYS_ID;
         3'd1: rd_mux = TIMESTAMP;
`ifdef SYSID_UPTIME_EN
         3'd2: rd_mux = uptime[31:0];
         3'd3: rd_mux = uptime_hi_shadow;
         3'd6: rd_mux = {30'b0, freeze, 1'b0};
`endif
         3'd4: rd_mux = scratch;
         3'd5: rd_mux = CAPS;
         default: rd_mux = '0;
      endcase
   end

   // Data stages are zeroed when empty so readdata is 0 whenever readdatavalid is low.
   logic [31:0]             pipe_dat [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_vld;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_dat[i] <= '0;
      end else begin
         pipe_vld[0] <= rd_acc;
         pipe_dat[0] <= rd_acc ? rd_mux : 32'd0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end
      end
   end

   assign readdata      = pipe_dat[READ_LATENCY-1];
   assign readdatavalid = pipe_vld[READ_LATENCY-1];

endmodule
